// File: rtl/cpu_pkg.sv
// picoMIPS shared definitions: instruction field layout, opcodes, Gaussian kernel
// and the instruction-generator state type.
package cpu_pkg;

    localparam int I_WIDTH = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 10;
    localparam int CLR_MSB = 9;
    localparam int CLR_LSB = 8;
    localparam int IMM_MSB = 7;

    localparam logic [1:0] CLR_ACC = 2'b01;

    localparam int N_K = 5;
    localparam logic [N_K-1:0][7:0] K = {8'h11, 8'h1D, 8'h23, 8'h1D, 8'h11};

    typedef enum logic [5:0] {
        NOP = 6'd0,
        MUL = 6'd1,
        ADD = 6'd2,
        END = 6'd3
    } opcode_t;

    typedef struct packed {
        logic [OPC_MSB-OPC_LSB:0] opcode;
        logic [CLR_MSB-CLR_LSB:0] clr;
        logic [IMM_MSB:0]         imm;
    } instr_t;

    typedef enum logic [2:0] {
        G_IDLE,
        G_MUL,
        G_ADD,
        G_END,
        G_DONE
    } genState_t;

    function automatic instr_t encode(opcode_t op, logic [1:0] clr, logic [7:0] imm);
        instr_t w;
        w.opcode = op;
        w.clr    = clr;
        w.imm    = imm;
        return w;
    endfunction

endpackage

// File: rtl/gauss_instr_gen_if.sv
// Instruction stream channel: producer drives instr/instr_valid, consumer drives instr_ready.
interface gauss_instr_gen_if #(
    parameter int I_WIDTH = cpu_pkg::I_WIDTH
);
    logic [I_WIDTH-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/gauss_instr_gen.sv
// Emits the Gaussian-filter picoMIPS program (MUL/ADD per tap, per window) followed
// by END, over a valid/ready channel with registered outputs.
module gauss_instr_gen
    import cpu_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int N_TAPS    = 5
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] n_windows,
    gauss_instr_gen_if.master    ibus,
    output logic                 busy,
    output logic                 done
);

    localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

    genState_t            state_q, state_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    logic [CNT_WIDTH-1:0] win_rem_q, win_rem_d;
    instr_t               instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 armed_q, armed_d;
    logic                 xfer;

    assign xfer = valid_q && ibus.instr_ready;

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        win_rem_d = win_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // armed_q masks a start that coincides with the first edge after reset release
        armed_d   = 1'b1;

        case (state_q)
            G_IDLE: begin
                if (start && armed_q) begin
                    win_rem_d = n_windows;
                    tap_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = (n_windows == '0) ? G_END : G_MUL;
                end
            end
            G_MUL: begin
                if (xfer) state_d = G_ADD;
            end
            G_ADD: begin
                if (xfer) begin
                    if (tap_q != TAP_LAST) begin
                        tap_d   = tap_q + TAP_W'(1);
                        state_d = G_MUL;
                    end else begin
                        tap_d     = '0;
                        win_rem_d = win_rem_q - CNT_WIDTH'(1);
                        state_d   = (win_rem_q == CNT_WIDTH'(1)) ? G_END : G_MUL;
                    end
                end
            end
            G_END: begin
                if (xfer) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = G_DONE;
                end
            end
            G_DONE: state_d = G_IDLE;
            default: state_d = G_IDLE;
        endcase

        // Outputs are encoded from the next state so they register in step with it
        valid_d = (state_d == G_MUL) || (state_d == G_ADD) || (state_d == G_END);
        case (state_d)
            G_MUL:   instr_d = encode(MUL, 2'b00, K[tap_d]);
            G_ADD:   instr_d = encode(ADD, (tap_d == '0) ? CLR_ACC : 2'b00, 8'h00);
            G_END:   instr_d = encode(END, 2'b00, 8'h00);
            default: instr_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= G_IDLE;
            tap_q     <= '0;
            win_rem_q <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            win_rem_q <= win_rem_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            armed_q   <= armed_d;
        end
    end

    assign ibus.instr       = instr_q;
    assign ibus.instr_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/gauss_instr_gen.md
Name: gauss_instr_gen

Overview:
- Instruction-stream generator: the encoder end of the picoMIPS 16-bit instruction format.
- On a start pulse it emits the Gaussian-filter program for a requested number of pixel windows, then a terminating END.
- Sits between the host/test controller and the CPU instruction input.
- Uses a valid/ready handshake so the CPU can stall it.

Parameters:
- I_WIDTH, 16, instruction width (from cpu_pkg)
- CNT_WIDTH, 8, width of the window-count input and window counter
- N_TAPS, 5, kernel taps per window (indexes cpu_pkg K)

Ports:
- clk  in  1  system clock, rising edge
- n_reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a program; ignored while busy
- n_windows  in  CNT_WIDTH  number of windows to encode; sampled when start is accepted
- instr  out  I_WIDTH  encoded instruction word
- instr_valid  out  1  instr holds a valid instruction
- instr_ready  in  1  consumer accepts instr this cycle
- busy  out  1  generator active (start accepted, END not yet accepted)
- done  out  1  one-cycle pulse in the cycle after END is accepted

Behaviour:
- Reset is asynchronous and active-low. While n_reset=0: state=IDLE, instr=0, instr_valid=0, busy=0, done=0, counters=0. Reset mid-program aborts with no END emitted.
- Encoding, fields MSB first:
  - opcode[15:10], then clr[9:8], then imm[7:0].
  - clr=2'b01 only on the ADD of tap 0 of each window (accumulator clear); otherwise 2'b00.
  - MUL: opcode MUL, imm=K[tap].
  - ADD: opcode ADD, imm=0.
  - END: opcode END, imm=0.
- FSM states: IDLE, MUL, ADD, END, DONE.
  - IDLE: on start, latch n_windows into win_rem, set tap=0, busy=1. Next state is END if n_windows==0, else MUL.
  - MUL: present MUL K[tap]; on handshake -> ADD.
  - ADD: present ADD; on handshake:
    - tap<N_TAPS-1: tap++ -> MUL.
    - Otherwise: tap=0, win_rem-- ; win_rem==1 (last window) -> END, else -> MUL.
  - END: present END; on handshake -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Handshake:
  - A transfer occurs when instr_valid && instr_ready at a rising edge.
  - instr_valid is high in MUL/ADD/END only.
  - instr must remain stable while instr_valid && !instr_ready.
  - instr_valid never drops without a transfer, except on reset.
- Latency:
  - First instruction is valid the cycle after start.
  - With instr_ready held high, one instruction per cycle: 10*n_windows+1 cycles of valid, then done on the following cycle.
- instr and instr_valid are registered outputs (no combinational path from instr_ready).
- start while busy (including DONE) is ignored; start coincident with reset release is ignored.
- n_windows=2^CNT_WIDTH-1 (255) must complete without counter wrap. win_rem counts down and never underflows.
- When instr_valid=0, instr reads 0.

Decomposition:
- Add to cpu_pkg:
  - field constants OPC_MSB=15, OPC_LSB=10, CLR_MSB=9, CLR_LSB=8, IMM_MSB=7.
  - CLR_ACC=2'b01.
  - a packed struct instr_t {opcode[5:0], clr[1:0], imm[7:0]}.
  - a state enum genState_t.
- Reuse MUL/ADD/END and K from cpu_pkg.
- Single module. An optional function encode(opcode, clr, imm) goes in the package; no sub-module needed.

Test Plan:
1. Reset asserted mid-stream (after 3 transfers) -> instr_valid=0, busy=0 immediately (async); restart with n_windows=1 emits a fresh sequence from 0x0411.
2. start with n_windows=1, instr_ready=1 -> sequence 0x0411, 0x0900, 0x041D, 0x0800, 0x0423, 0x0800, 0x041D, 0x0800, 0x0411, 0x0800, 0x0C00. Then done pulses one cycle later and busy falls.
3. start with n_windows=0 -> single 0x0C00 one cycle after start, then done.
4. n_windows=2 with instr_ready toggling randomly -> 21 transfers; instr stable during every stall; the second window's first ADD is 0x0900.
5. start pulsed while busy (n_windows=3 running, second start with n_windows=1) -> ignored; total transfers=31.
6. n_windows=255, instr_ready=1 -> 2551 transfers, last is 0x0C00, no wrap, done asserted exactly once.
